// File: rtl/axi_lite_cmd_master_if.sv
// axi_lite_cmd_master_if
//   Bundles the command port, the response port and the five AXI4-Lite
//   channels of axi_lite_cmd_master. Signal names keep their original
//   i_/o_ prefixes, which describe direction as seen from the master.
//   master modport : used by axi_lite_cmd_master
//   slave  modport : used by whatever drives the command port and the AXI slave
//   Parameters: ADDR_WIDTH, DATA_WIDTH (32 or 64), STROBE_WIDTH (DATA_WIDTH/8)
interface axi_lite_cmd_master_if #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STROBE_WIDTH = DATA_WIDTH / 8
);
  // command port
  logic                    i_cmd_valid;
  logic                    o_cmd_ready;
  logic                    i_cmd_write;
  logic [ADDR_WIDTH-1:0]   i_cmd_addr;
  logic [DATA_WIDTH-1:0]   i_cmd_data;
  logic [STROBE_WIDTH-1:0] i_cmd_strb;
  // response port
  logic                    o_rsp_valid;
  logic                    i_rsp_ready;
  logic                    o_rsp_write;
  logic [1:0]              o_rsp_resp;
  logic [DATA_WIDTH-1:0]   o_rsp_data;
  // AXI4-Lite channels
  logic                    o_awvalid;
  logic [ADDR_WIDTH-1:0]   o_awaddr;
  logic                    i_awready;
  logic                    o_wvalid;
  logic [DATA_WIDTH-1:0]   o_wdata;
  logic [STROBE_WIDTH-1:0] o_wstrb;
  logic                    i_wready;
  logic                    i_bvalid;
  logic                    o_bready;
  logic [1:0]              i_bresp;
  logic                    o_arvalid;
  logic [ADDR_WIDTH-1:0]   o_araddr;
  logic                    i_arready;
  logic                    i_rvalid;
  logic                    o_rready;
  logic [1:0]              i_rresp;
  logic [DATA_WIDTH-1:0]   i_rdata;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_data, i_cmd_strb,
    output o_cmd_ready,
    input  i_rsp_ready,
    output o_rsp_valid, o_rsp_write, o_rsp_resp, o_rsp_data,
    output o_awvalid, o_awaddr, input i_awready,
    output o_wvalid, o_wdata, o_wstrb, input i_wready,
    input  i_bvalid, i_bresp, output o_bready,
    output o_arvalid, o_araddr, input i_arready,
    input  i_rvalid, i_rresp, i_rdata, output o_rready
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_data, i_cmd_strb,
    input  o_cmd_ready,
    output i_rsp_ready,
    input  o_rsp_valid, o_rsp_write, o_rsp_resp, o_rsp_data,
    input  o_awvalid, o_awaddr, output i_awready,
    input  o_wvalid, o_wdata, o_wstrb, output i_wready,
    output i_bvalid, i_bresp, input o_bready,
    input  o_arvalid, o_araddr, output i_arready,
    output i_rvalid, i_rresp, i_rdata, input o_rready
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
//   Single-outstanding AXI4-Lite master. A command (read or write) is taken
//   on the command port, the matching AXI-Lite transaction is run, and one
//   response per command is returned on the response port. All outputs are
//   registered.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset; aborts any transaction silently
//   bus    : axi_lite_cmd_master_if.master (command, response, AW/W/B/AR/R)
//   o_busy : high whenever the FSM is not in IDLE
// Optional build macro:
//   AXI_LITE_CMD_MASTER_TIMEOUT_EN - abort a stalled transaction after
//   TIMEOUT_CYCLES cycles and answer with resp 2'b11, data 0.
module axi_lite_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_lite_cmd_master_if.master bus,
  output logic                  o_busy
);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || STROBE_WIDTH != DATA_WIDTH / 8 ||
      TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axi_lite_cmd_master: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
  } state_e;

  // Every output is a field here so that the whole output set is one register.
  typedef struct packed {
    state_e                  state;
    logic                    cmd_ready;
    logic                    awvalid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [STROBE_WIDTH-1:0] wstrb;
    logic                    bready;
    logic                    arvalid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rready;
    logic                    rsp_valid;
    logic                    rsp_write;
    logic [1:0]              rsp_resp;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic                    busy;
    logic                    aw_done;
    logic                    w_done;
  } regs_t;

  regs_t r_q, r_d;
  logic  accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_done, w_done;

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          active;
`endif

  always_comb begin
    r_d     = r_q;
    accept  = (r_q.state == IDLE) && r_q.cmd_ready && bus.i_cmd_valid;
    aw_hs   = r_q.awvalid && bus.i_awready;
    w_hs    = r_q.wvalid && bus.i_wready;
    b_hs    = r_q.bready && bus.i_bvalid;
    ar_hs   = r_q.arvalid && bus.i_arready;
    r_hs    = r_q.rready && bus.i_rvalid;
    aw_done = r_q.aw_done || aw_hs;
    w_done  = r_q.w_done || w_hs;

    case (r_q.state)
      IDLE: begin
        if (accept) begin
          r_d.rsp_write = bus.i_cmd_write;
          r_d.aw_done   = 1'b0;
          r_d.w_done    = 1'b0;
          if (bus.i_cmd_write) begin
            r_d.state   = WR_ADDR_DATA;
            r_d.awvalid = 1'b1;
            r_d.awaddr  = bus.i_cmd_addr;
            r_d.wvalid  = 1'b1;
            r_d.wdata   = bus.i_cmd_data;
            r_d.wstrb   = bus.i_cmd_strb;
          end else begin
            r_d.state   = RD_ADDR;
            r_d.arvalid = 1'b1;
            r_d.araddr  = bus.i_cmd_addr;
          end
        end
      end
      WR_ADDR_DATA: begin
        if (aw_hs) begin
          r_d.awvalid = 1'b0;
          r_d.aw_done = 1'b1;
        end
        if (w_hs) begin
          r_d.wvalid = 1'b0;
          r_d.w_done = 1'b1;
        end
        if (aw_done && w_done) begin
          r_d.state  = WR_RESP;
          r_d.bready = 1'b1;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          r_d.bready    = 1'b0;
          r_d.rsp_resp  = bus.i_bresp;
          r_d.rsp_data  = '0;
          r_d.rsp_valid = 1'b1;
          r_d.state     = RESP;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          r_d.arvalid = 1'b0;
          r_d.rready  = 1'b1;
          r_d.state   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          r_d.rready    = 1'b0;
          r_d.rsp_resp  = bus.i_rresp;
          r_d.rsp_data  = bus.i_rdata;
          r_d.rsp_valid = 1'b1;
          r_d.state     = RESP;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          r_d.rsp_valid = 1'b0;
          r_d.state     = IDLE;
        end
      end
      default: r_d.state = IDLE;
    endcase

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    active = r_q.state inside {WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA};
    tmo_d  = tmo_q;
    if (accept) begin
      tmo_d = '0;
    end else if (active && tmo_q != TMO_LAST) begin
      tmo_d = tmo_q + 1'b1;
    end
    // A handshake that moves the FSM on in the expiry cycle wins; the counter
    // stays saturated, so the timeout fires on the next cycle that stalls.
    if (active && tmo_q == TMO_LAST && r_d.state == r_q.state) begin
      r_d.awvalid   = 1'b0;
      r_d.wvalid    = 1'b0;
      r_d.bready    = 1'b0;
      r_d.arvalid   = 1'b0;
      r_d.rready    = 1'b0;
      r_d.rsp_resp  = 2'b11;
      r_d.rsp_data  = '0;
      r_d.rsp_valid = 1'b1;
      r_d.state     = RESP;
    end
`endif

    r_d.cmd_ready = (r_d.state == IDLE);
    r_d.busy      = (r_d.state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      r_q.state <= IDLE;
    end else begin
      r_q <= r_d;
    end
  end

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign bus.o_cmd_ready = r_q.cmd_ready;
  assign bus.o_rsp_valid = r_q.rsp_valid;
  assign bus.o_rsp_write = r_q.rsp_write;
  assign bus.o_rsp_resp  = r_q.rsp_resp;
  assign bus.o_rsp_data  = r_q.rsp_data;
  assign bus.o_awvalid   = r_q.awvalid;
  assign bus.o_awaddr    = r_q.awaddr;
  assign bus.o_wvalid    = r_q.wvalid;
  assign bus.o_wdata     = r_q.wdata;
  assign bus.o_wstrb     = r_q.wstrb;
  assign bus.o_bready    = r_q.bready;
  assign bus.o_arvalid   = r_q.arvalid;
  assign bus.o_araddr    = r_q.araddr;
  assign bus.o_rready    = r_q.rready;
  assign o_busy          = r_q.busy;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master
//   Drives axi_lite_cmd_master with a command driver, a behavioural AXI-Lite
//   slave with configurable stalls, and a response monitor that pops
//   expected responses from a scoreboard queue.
module tb_axi_lite_cmd_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  axi_lite_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_WIDTH(SW)) bus ();

  axi_lite_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_WIDTH(SW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_busy(busy)
  );

  typedef struct {
    logic        write;
    logic [1:0]  resp;
    logic [31:0] data;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] sb_mem [16];
  logic [31:0] sl_mem [16];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;

  // slave configuration
  int unsigned aw_delay  = 0;
  logic        b_never   = 1'b0;
  logic        r_hold    = 1'b0;
  logic [1:0]  rresp_cfg = 2'b00;

  // monitor state
  logic        aw_mon      = 1'b0;
  logic [31:0] aw_mon_addr = '0;
  int unsigned aw_hi = 0;
  int unsigned w_hi  = 0;
  logic        rsp_seen  = 1'b0;
  int unsigned rsp_first = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural AXI-Lite slave. Ready/valid are set at the falling edge, so
  // a handshake decided here completes on the following rising edge.
  logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  logic [31:0] sl_awaddr = '0, sl_wdata = '0, sl_araddr = '0;
  logic [3:0]  sl_wstrb = '0;
  int unsigned aw_wait = 0;

  initial begin
    bus.i_awready = 1'b0; bus.i_wready = 1'b0; bus.i_arready = 1'b0;
    bus.i_bvalid  = 1'b0; bus.i_bresp  = 2'b00;
    bus.i_rvalid  = 1'b0; bus.i_rresp  = 2'b00; bus.i_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
        aw_wait = 0;
        bus.i_awready = 1'b0; bus.i_wready = 1'b0; bus.i_arready = 1'b0;
        bus.i_bvalid  = 1'b0; bus.i_rvalid = 1'b0;
      end else begin
        if (aw_got && w_got) begin
          for (int b = 0; b < 4; b++)
            if (sl_wstrb[b]) sl_mem[sl_awaddr[5:2]][8*b +: 8] = sl_wdata[8*b +: 8];
          b_pend = !b_never;
          aw_got = 1'b0;
          w_got  = 1'b0;
        end
        if (ar_got) begin
          r_pend        = 1'b1;
          bus.i_rdata   = sl_mem[sl_araddr[5:2]];
          bus.i_rresp   = rresp_cfg;
          ar_got        = 1'b0;
        end
        bus.i_awready = 1'b0;
        if (bus.o_awvalid) begin
          if (aw_wait >= aw_delay) begin
            bus.i_awready = 1'b1;
            aw_got        = 1'b1;
            sl_awaddr     = bus.o_awaddr;
            aw_wait       = 0;
          end else begin
            aw_wait++;
          end
        end
        bus.i_wready = bus.o_wvalid;
        if (bus.o_wvalid) begin
          w_got    = 1'b1;
          sl_wdata = bus.o_wdata;
          sl_wstrb = bus.o_wstrb;
        end
        bus.i_arready = bus.o_arvalid;
        if (bus.o_arvalid) begin
          ar_got    = 1'b1;
          sl_araddr = bus.o_araddr;
        end
        bus.i_bvalid = b_pend;
        bus.i_bresp  = 2'b00;
        if (b_pend && bus.o_bready) b_pend = 1'b0;
        bus.i_rvalid = r_pend && !r_hold;
        if (bus.i_rvalid && bus.o_rready) r_pend = 1'b0;
      end
    end
  end

  // Response monitor and protocol observers.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_seen = 1'b0;
      end else begin
        if (busy) check("ready_while_busy", 64'(bus.o_cmd_ready), 64'd0);
        if (bus.o_bready)
          check("bready_with_aw_w", 64'({bus.o_awvalid, bus.o_wvalid}), 64'd0);
        if (aw_mon) begin
          if (bus.o_awvalid) begin
            aw_hi++;
            check("awaddr_stable", 64'(bus.o_awaddr), 64'(aw_mon_addr));
          end
          if (bus.o_wvalid) w_hi++;
        end
        if (bus.o_rsp_valid) begin
          if (!rsp_seen) begin
            rsp_seen  = 1'b1;
            rsp_first = cyc + 1;
          end
          if (bus.i_rsp_ready) begin
            rsp_seen = 1'b0;
            if (sbq.size() == 0) begin
              check("unexpected_rsp", 64'(bus.o_rsp_valid), 64'd0);
            end else begin
              mon_e = sbq.pop_front();
              check("rsp_write", 64'(bus.o_rsp_write), 64'(mon_e.write));
              check("rsp_resp",  64'(bus.o_rsp_resp),  64'(mon_e.resp));
              check("rsp_data",  64'(bus.o_rsp_data),  64'(mon_e.data));
              if (mon_e.lat != 0)
                check("rsp_latency", 64'(rsp_first - mon_e.acc), 64'(mon_e.lat));
            end
          end
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [1:0] exp_resp,
                      input int unsigned lat, input logic push);
    exp_t        e;
    int unsigned n;
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = wr;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_data  = data;
    bus.i_cmd_strb  = strb;
    n = 0;
    while (!bus.o_cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 64'(bus.o_cmd_ready), 64'd1);
    e.write = wr;
    e.resp  = exp_resp;
    e.lat   = lat;
    e.acc   = cyc + 1;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) sb_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
      e.data = '0;
    end else begin
      e.data = sb_mem[addr[5:2]];
    end
    if (push) sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sbq.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stall_data;
    int unsigned n;
    bus.i_cmd_valid = 1'b0; bus.i_cmd_write = 1'b0; bus.i_cmd_addr = '0;
    bus.i_cmd_data  = '0;   bus.i_cmd_strb  = '0;   bus.i_rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sb_mem[i] = '0;
      sl_mem[i] = '0;
    end

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
    check("rst_valids", 64'({bus.o_awvalid, bus.o_wvalid, bus.o_bready, bus.o_arvalid,
                             bus.o_rready, bus.o_rsp_valid}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addr", {bus.o_awaddr, bus.o_araddr}, 64'd0);
    check("rst_data", {bus.o_wdata, bus.o_rsp_data}, 64'd0);
    check("rst_strb_resp", 64'({bus.o_wstrb, bus.o_rsp_resp, bus.o_rsp_write}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("cmd_ready_after_rst", 64'(bus.o_cmd_ready), 64'd1);

    // zero-wait write then read of the same word
    send(1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, 2'b00, 3, 1'b1);
    drain();
    send(1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 3, 1'b1);
    drain();

    // second word, reads issued back to back
    send(1'b1, 32'h4, 32'h1234_5678, 4'hF, 2'b00, 3, 1'b1);
    drain();
    send(1'b0, 32'h4, 32'h0, 4'h0, 2'b00, 3, 1'b1);
    send(1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 3, 1'b1);
    drain();

    // AW accepted three cycles late, W immediately; partial strobe
    aw_delay    = 3;
    aw_mon      = 1'b1;
    aw_mon_addr = 32'hC;
    aw_hi       = 0;
    w_hi        = 0;
    send(1'b1, 32'hC, 32'hA5A5_0F0F, 4'h5, 2'b00, 0, 1'b1);
    drain();
    aw_mon   = 1'b0;
    aw_delay = 0;
    check("awvalid_cycles", 64'(aw_hi), 64'd4);
    check("wvalid_cycles",  64'(w_hi),  64'd1);
    send(1'b0, 32'hC, 32'h0, 4'h0, 2'b00, 3, 1'b1);
    drain();

    // error response with a stalled response port
    rresp_cfg = 2'b10;
    @(posedge clk);
    #1;
    bus.i_rsp_ready = 1'b0;
    send(1'b0, 32'h8, 32'h0, 4'h0, 2'b10, 3, 1'b1);
    n = 0;
    while (!bus.o_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_rsp_seen", 64'(bus.o_rsp_valid), 64'd1);
    stall_data = sb_mem[2];
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = 1'b1;
    bus.i_cmd_addr  = 32'h3C;
    bus.i_cmd_data  = 32'hFFFF_FFFF;
    bus.i_cmd_strb  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.o_rsp_valid), 64'd1);
      check("stall_resp",  64'(bus.o_rsp_resp),  64'(2'b10));
      check("stall_data",  64'(bus.o_rsp_data),  64'(stall_data));
      check("stall_no_accept", 64'(bus.o_cmd_ready), 64'd0);
    end
    bus.i_cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.i_rsp_ready = 1'b1;
    drain();
    rresp_cfg = 2'b00;

    // reset while waiting for read data
    r_hold = 1'b1;
    send(1'b0, 32'h4, 32'h0, 4'h0, 2'b00, 0, 1'b0);
    n = 0;
    while (!bus.o_rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rready_seen", 64'(bus.o_rready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_channels", 64'({bus.o_arvalid, bus.o_rready, bus.o_rsp_valid}), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
    rst    = 1'b0;
    r_hold = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready_back", 64'(bus.o_cmd_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(bus.o_rsp_valid), 64'd0);
    end
    send(1'b0, 32'h4, 32'h0, 4'h0, 2'b00, 3, 1'b1);
    drain();

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    // slave never answers the write
    b_never = 1'b1;
    send(1'b1, 32'h10, 32'h0000_0001, 4'hF, 2'b11, 17, 1'b1);
    drain();
    check("tmo_bready", 64'(bus.o_bready), 64'd0);
    check("tmo_idle", 64'(busy), 64'd0);
    b_never = 1'b0;
    send(1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 3, 1'b1);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
